// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit turning core requests into aligned or byte-split data memory accesses
// Ports: i_clk, i_rst (sync, active-high); i_req_* request with valid/ready; o_rsp_* response with
// valid/ready; o_mem_*/i_mem_data data memory port (combinational read); o_misalign_cnt saturating count
typedef enum logic [1:0] {BYTE = 2'd0, HWORD = 2'd1, WORD = 2'd2} mem_op_sz_e;

module dmem_lsu #(
  parameter bit SplitMisaligned = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  mem_op_sz_e  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  output mem_op_sz_e  o_mem_size,
  input  logic [31:0] i_mem_data,
  output logic [15:0] o_misalign_cnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_e;
  state_e state, state_n;
  logic we_q, uns_q, err_q;
  logic [31:0] addr_q, wdata_q, asm_q, ext;
  mem_op_sz_e size_q;
  logic [1:0] idx;
  logic accept, mis, rej, last, busy;
  assign accept = state == IDLE && i_req_valid;
  assign mis = (i_req_size == HWORD && i_req_addr[0]) || (i_req_size == WORD && i_req_addr[1:0] != 2'd0);
  // unknown size encodings are rejected like misaligned requests in reject mode
  assign rej = !(i_req_size inside {BYTE, HWORD, WORD}) || (mis && !SplitMisaligned);
  assign last = idx == (size_q == WORD ? 2'd3 : 2'd1);
  assign busy = state == ACCESS || state == SPLIT;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = !i_req_valid ? IDLE : rej ? RESP : mis ? SPLIT : ACCESS;
      ACCESS:  state_n = RESP;
      SPLIT:   state_n = last ? RESP : SPLIT;
      RESP:    state_n = i_rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      idx <= '0;
      err_q <= 1'b0;
      o_misalign_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q <= i_req_we;
        addr_q <= i_req_addr;
        wdata_q <= i_req_wdata;
        size_q <= i_req_size;
        uns_q <= i_req_unsigned;
        err_q <= rej;
        idx <= '0;
        asm_q <= '0;
        if (mis && o_misalign_cnt != 16'hFFFF) o_misalign_cnt <= o_misalign_cnt + 16'd1;
      end
      if (state == ACCESS && !we_q) asm_q <= i_mem_data;
      if (state == SPLIT) begin
        idx <= idx + 2'd1;
        if (!we_q) asm_q[{idx, 3'b000} +: 8] <= i_mem_data[7:0];
      end
    end
  end
  assign ext = size_q == BYTE  ? {{24{!uns_q && asm_q[7]}}, asm_q[7:0]} :
               size_q == HWORD ? {{16{!uns_q && asm_q[15]}}, asm_q[15:0]} : asm_q;
  assign o_req_ready = state == IDLE;
  assign o_rsp_valid = state == RESP;
  assign o_rsp_err = state == RESP && err_q;
  assign o_rsp_rdata = (state == RESP && !err_q && !we_q) ? ext : '0;
  assign o_mem_we = busy && we_q;
  assign o_mem_re = busy && !we_q;
  assign o_mem_addr = state == ACCESS ? addr_q : state == SPLIT ? addr_q + {30'd0, idx} : '0;
  assign o_mem_data = state == ACCESS ? wdata_q : state == SPLIT ? {24'd0, wdata_q[{idx, 3'b000} +: 8]} : '0;
  assign o_mem_size = state == ACCESS ? size_q : BYTE;
endmodule
